// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time over valid/ready, drives a combinational-read,
// clocked-write data memory with sized access, sign/zero extension, RMW partial stores and fault checks.
module load_store_unit #(
    parameter int MEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    output logic [63:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [63:0] mem_address,
    output logic [63:0] mem_writeData,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    input  logic [63:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic        misaligned;
    logic        out_of_range;
    logic [64:0] end_addr;
    logic [7:0]  byte_en;
    logic [63:0] merge_data;
    logic [63:0] load_ext;

    // 65-bit sum so that addresses near 2^64 wrap into a fault rather than back into range
    assign end_addr     = {1'b0, req_addr} + 65'd8;
    assign out_of_range = end_addr > 65'(MEM_BYTES);

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = |req_addr[2:0];
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign byte_en[gi] = 4'(gi) < (4'd1 << size_q);
            assign merge_data[gi*8 +: 8] = byte_en[gi] ? wdata_q[gi*8 +: 8] : rdata_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        load_ext = rdata_q;
        case (size_q)
            2'b00:   load_ext = {{56{~unsigned_q & rdata_q[7]}},  rdata_q[7:0]};
            2'b01:   load_ext = {{48{~unsigned_q & rdata_q[15]}}, rdata_q[15:0]};
            2'b10:   load_ext = {{32{~unsigned_q & rdata_q[31]}}, rdata_q[31:0]};
            default: load_ext = rdata_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    rdata_d    = '0;
                    fault_d    = misaligned | out_of_range;
                    if (misaligned | out_of_range)
                        state_d = RESP;
                    else if (req_write && (req_size == 2'b11))
                        state_d = WR;
                    else
                        state_d = RD;
                end
            end
            RD: begin
                rdata_d = mem_read_data;
                state_d = write_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            fault_q    <= fault_d;
        end
    end

    // Strobes decode straight from state so an async reset kills a pending write before the edge
    assign req_ready     = (state_q == IDLE);
    assign mem_MemRead   = (state_q == RD);
    assign mem_MemWrite  = (state_q == WR);
    assign mem_address   = addr_q;
    assign mem_writeData = (state_q == WR) ? merge_data : '0;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_fault     = (state_q == RESP) && fault_q;
    assign rsp_rdata     = ((state_q == RESP) && !fault_q && !write_q) ? load_ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, directed spec cases, reset abort,
// randomized requests and a held-valid stream checked against a byte-level reference model.
module tb_load_store_unit;
    localparam int MEM_BYTES = 128;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_fault;
    logic [63:0] mem_address;
    logic [63:0] mem_writeData;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [63:0] mem_read_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem     [0:MEM_BYTES-1];
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .mem_address(mem_address), .mem_writeData(mem_writeData),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: initialised Mem[i]=i+1, combinational 8-byte read, 8-byte write on posedge
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'(i + 1);
        forever begin
            @(posedge clk);
            if (mem_MemWrite && mem_address <= 64'(MEM_BYTES - 8))
                for (int i = 0; i < 8; i++) mem[int'(mem_address) + i] <= mem_writeData[i*8 +: 8];
        end
    end

    always_comb begin
        mem_read_data = '0;
        if (mem_address <= 64'(MEM_BYTES - 8))
            for (int i = 0; i < 8; i++) mem_read_data[i*8 +: 8] = mem[int'(mem_address) + i];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (mem_MemRead && mem_MemWrite) begin
                failures++;
                $display("FAIL strobe_exclusive: MemRead=%0b MemWrite=%0b, required not both 1", mem_MemRead, mem_MemWrite);
            end
        end
    end

    // Reference model: byte-addressed memory, access size n = 2^size bytes
    function automatic void model(input logic w, input logic [1:0] sz, input logic uns,
                                  input logic [63:0] a, input logic [63:0] wd,
                                  output logic [63:0] rd, output logic flt,
                                  output int lat, output int nrd, output int nwr);
        int n;
        logic [71:0] last;
        n    = 1 << sz;
        last = 72'(a) + 72'd8;
        rd   = '0;
        flt  = ((a % 64'(n)) != 0) || (last > 72'(MEM_BYTES));
        if (flt) begin
            lat = 1; nrd = 0; nwr = 0;
        end else if (!w) begin
            for (int i = 0; i < n; i++) rd = rd | (64'(ref_mem[int'(a) + i]) << (8 * i));
            if (!uns && n < 8 && rd[8*n-1]) rd = rd | ({64{1'b1}} << (8 * n));
            lat = 2; nrd = 1; nwr = 0;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            lat = (n == 8) ? 2 : 3; nrd = (n == 8) ? 0 : 1; nwr = 1;
        end
    endfunction

    task automatic rand_req(output logic w, output logic [1:0] sz, output logic uns,
                            output logic [63:0] a, output logic [63:0] wd);
        int n;
        w   = 1'($urandom_range(0, 1));
        sz  = 2'($urandom_range(0, 3));
        uns = 1'($urandom_range(0, 1));
        wd  = {$urandom, $urandom};
        n   = 1 << sz;
        case ($urandom_range(0, 9))
            0:       a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
            1:       a = 64'($urandom_range(121, 200));
            default: begin
                a = 64'($urandom_range(0, 120));
                if ($urandom_range(0, 3) != 0) a = a & ~64'(n - 1);
            end
        endcase
    endtask

    // Drives one request and observes its response; no checking here
    task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                          input logic [63:0] a, input logic [63:0] wd,
                          output logic [63:0] rd, output logic flt, output int lat,
                          output int nrd, output int nwr, output logic [63:0] wseen,
                          output logic tmo);
        int guard;
        guard = 0;
        tmo = 1'b1; rd = '0; flt = 1'b0; lat = 0; nrd = 0; nwr = 0; wseen = '0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) return;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_MemRead) nrd++;
            if (mem_MemWrite) begin
                nwr++;
                wseen = mem_writeData;
            end
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; flt = rsp_fault; tmo = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i + 1);
        #2;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: ready=%b valid=%b fault=%b, required 1 0 0", req_ready, rsp_valid, rsp_fault);
        end
        checks++;
        if (rsp_rdata !== 64'd0 || mem_address !== 64'd0 || mem_writeData !== 64'd0) begin
            failures++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h, required all 0", rsp_rdata, mem_address, mem_writeData);
        end
        checks++;
        if (mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: MemRead=%b MemWrite=%b, required 0 0", mem_MemRead, mem_MemWrite);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released at %0t", $time);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        uns;
        logic [63:0] a;
        logic [63:0] wd;
        logic [63:0] erd;
        logic        eflt;
        int          elat;
        int          enrd;
        int          enwr;
    } dir_t;

    task automatic test_directed();
        dir_t tbl [8];
        logic [63:0] rd, mrd, wseen;
        logic flt, mflt, tmo;
        int lat, nrd, nwr, mlat, mnrd, mnwr;
        tbl[0] = '{1'b0, 2'b11, 1'b0, 64'd0,   64'd0,  64'h0807060504030201, 1'b0, 2, 1, 0};
        tbl[1] = '{1'b0, 2'b01, 1'b0, 64'd4,   64'd0,  64'h0000000000000605, 1'b0, 2, 1, 0};
        tbl[2] = '{1'b1, 2'b00, 1'b0, 64'd8,   64'h9A, 64'h0,                1'b0, 3, 1, 1};
        tbl[3] = '{1'b0, 2'b00, 1'b0, 64'd8,   64'd0,  64'hFFFFFFFFFFFFFF9A, 1'b0, 2, 1, 0};
        tbl[4] = '{1'b0, 2'b00, 1'b1, 64'd8,   64'd0,  64'h000000000000009A, 1'b0, 2, 1, 0};
        tbl[5] = '{1'b0, 2'b11, 1'b0, 64'd8,   64'd0,  64'h100F0E0D0C0B0A9A, 1'b0, 2, 1, 0};
        tbl[6] = '{1'b0, 2'b10, 1'b0, 64'd2,   64'd0,  64'h0,                1'b1, 1, 0, 0};
        tbl[7] = '{1'b0, 2'b11, 1'b0, 64'd124, 64'd0,  64'h0,                1'b1, 1, 0, 0};
        for (int k = 0; k < 8; k++) begin
            model(tbl[k].w, tbl[k].sz, tbl[k].uns, tbl[k].a, tbl[k].wd, mrd, mflt, mlat, mnrd, mnwr);
            do_req(tbl[k].w, tbl[k].sz, tbl[k].uns, tbl[k].a, tbl[k].wd, rd, flt, lat, nrd, nwr, wseen, tmo);
            $display("directed %0d: w=%b size=%0d addr=%0d -> rdata=%h fault=%b lat=%0d reads=%0d writes=%0d",
                     k, tbl[k].w, tbl[k].sz, tbl[k].a, rd, flt, lat, nrd, nwr);
            checks++;
            if (tmo || rd !== tbl[k].erd || flt !== tbl[k].eflt) begin
                failures++;
                $display("FAIL directed_%0d_data: timeout=%b rdata=%h fault=%b, required rdata=%h fault=%b",
                         k, tmo, rd, flt, tbl[k].erd, tbl[k].eflt);
            end
            checks++;
            if (lat != tbl[k].elat || nrd != tbl[k].enrd || nwr != tbl[k].enwr) begin
                failures++;
                $display("FAIL directed_%0d_timing: lat=%0d reads=%0d writes=%0d, required %0d %0d %0d",
                         k, lat, nrd, nwr, tbl[k].elat, tbl[k].enrd, tbl[k].enwr);
            end
            if (tbl[k].w) begin
                checks++;
                if (wseen !== 64'h100F0E0D0C0B0A9A) begin
                    failures++;
                    $display("FAIL directed_%0d_merge: writeData=%h, required 100f0e0d0c0b0a9a", k, wseen);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [63:0] rd, mrd, wseen;
        logic flt, mflt, tmo;
        int lat, nrd, nwr, mlat, mnrd, mnwr, seen;
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
        req_addr = 64'd16; req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_MemWrite !== 1'b1) begin
            failures++;
            $display("FAIL abort_in_wr: MemWrite=%b, required 1 in WR", mem_MemWrite);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_MemWrite !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_address !== 64'd0) begin
            failures++;
            $display("FAIL abort_immediate: MemWrite=%b ready=%b rsp_valid=%b addr=%h, required 0 1 0 0",
                     mem_MemWrite, req_ready, rsp_valid, mem_address);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL abort_no_rsp: rsp_valid cycles=%0d, required 0", seen);
        end
        model(1'b0, 2'b11, 1'b0, 64'd16, 64'd0, mrd, mflt, mlat, mnrd, mnwr);
        do_req(1'b0, 2'b11, 1'b0, 64'd16, 64'd0, rd, flt, lat, nrd, nwr, wseen, tmo);
        $display("abort follow-up load addr=16 -> rdata=%h fault=%b", rd, flt);
        checks++;
        if (tmo || rd !== 64'h1817161514131211 || flt !== 1'b0) begin
            failures++;
            $display("FAIL abort_followup: timeout=%b rdata=%h fault=%b, required 1817161514131211 0", tmo, rd, flt);
        end
    endtask

    task automatic test_random();
        logic w, uns, flt, eflt, tmo;
        logic [1:0] sz;
        logic [63:0] a, wd, rd, erd, wseen;
        int lat, nrd, nwr, elat, enrd, enwr;
        for (int k = 0; k < 80; k++) begin
            rand_req(w, sz, uns, a, wd);
            model(w, sz, uns, a, wd, erd, eflt, elat, enrd, enwr);
            do_req(w, sz, uns, a, wd, rd, flt, lat, nrd, nwr, wseen, tmo);
            $display("random %0d: w=%b size=%0d uns=%b addr=%h -> rdata=%h fault=%b lat=%0d",
                     k, w, sz, uns, a, rd, flt, lat);
            checks++;
            if (tmo || rd !== erd || flt !== eflt || lat != elat || nrd != enrd || nwr != enwr) begin
                failures++;
                $display("FAIL random_%0d: timeout=%b rdata=%h fault=%b lat=%0d r=%0d w=%0d, required rdata=%h fault=%b lat=%0d r=%0d w=%0d",
                         k, tmo, rd, flt, lat, nrd, nwr, erd, eflt, elat, enrd, enwr);
            end
        end
    endtask

    typedef struct {
        logic [63:0] rd;
        logic        flt;
    } exp_t;

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        logic w, uns, prev_rsp;
        logic [1:0] sz;
        logic [63:0] a, wd, erd;
        logic eflt;
        int elat, enrd, enwr, accepts, rsps;
        accepts = 0; rsps = 0; prev_rsp = 1'b0;
        rand_req(w, sz, uns, a, wd);
        req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        for (int cyc = 0; cyc < 170; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rsps++;
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra_rsp: rdata=%h fault=%b, required no response", rsp_rdata, rsp_fault);
                end else begin
                    e = q.pop_front();
                    $display("b2b rsp %0d: rdata=%h fault=%b", rsps, rsp_rdata, rsp_fault);
                    if (rsp_rdata !== e.rd || rsp_fault !== e.flt || prev_rsp) begin
                        failures++;
                        $display("FAIL b2b_rsp_%0d: rdata=%h fault=%b back_to_back=%b, required rdata=%h fault=%b back_to_back=0",
                                 rsps, rsp_rdata, rsp_fault, prev_rsp, e.rd, e.flt);
                    end
                end
            end
            prev_rsp = rsp_valid;
            if (cyc >= 160) begin
                req_valid = 1'b0;
            end else begin
                req_valid = 1'b1;
                if (req_ready) begin
                    model(req_write, req_size, req_unsigned, req_addr, req_wdata, erd, eflt, elat, enrd, enwr);
                    q.push_back('{erd, eflt});
                    accepts++;
                end else begin
                    rand_req(w, sz, uns, a, wd);
                    req_write = w; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
                end
            end
        end
        checks++;
        if (q.size() != 0 || accepts != rsps || accepts < 20) begin
            failures++;
            $display("FAIL b2b_count: accepts=%0d responses=%0d pending=%0d, required equal, none pending, >=20",
                     accepts, rsps, q.size());
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL memory_image: %0d bytes differ, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_abort();
        test_random();
        test_back_to_back();
        @(negedge clk);
        test_memory_image();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
